mux_capture: RTL and testbench

MUX_CAPTURE -- requirements
Module: mux_capture

---
 rtl/mux_capture.sv | 93 +++++++++
 tb/tb_mux_capture.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mux_capture.sv
`default_nettype none
// ============================================================================
// Module   : mux_capture
// Brief    : N-channel registered mux capture with manual select or auto-scan;
//            invalid manual selects pulse err. MUX_CAPTURE_ERRCNT_EN adds a
//            saturating 8-bit err_cnt output.
// Revision : 1.0 - initial release
// ============================================================================
module mux_capture #(
    parameter  int N  = 3,
    parameter  int W  = 2,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] idata,
    input  logic [SW-1:0]  sel,
    input  logic           le,
    input  logic           scan,
    output logic [W-1:0]   dout,
    output logic [SW-1:0]  ch,
    output logic           valid,
    output logic           err
`ifdef MUX_CAPTURE_ERRCNT_EN
    ,
    output logic [7:0]     err_cnt
`endif
);

    localparam int           c_NSLOT = 2 ** SW;
    localparam logic [SW:0]  c_N     = (SW + 1)'(N);
    localparam logic [SW-1:0] c_LAST = SW'(N - 1);

    logic [SW-1:0] r_scan_cnt;
    logic [SW-1:0] w_eff;
    logic          w_in_range;
    logic          w_capture;
    logic          w_bad_load;
    logic [W-1:0]  w_chan [c_NSLOT];

    // Pad the channel table to a power of two so any select value indexes safely.
    for (genvar i = 0; i < c_NSLOT; i++) begin : g_chan
        if (i < N) begin : g_real
            assign w_chan[i] = idata[i*W +: W];
        end else begin : g_pad
            assign w_chan[i] = '0;
        end
    end

    assign w_eff      = scan ? r_scan_cnt : sel;
    assign w_in_range = ({1'b0, w_eff} < c_N);
    assign w_capture  = le && w_in_range;
    assign w_bad_load = le && !scan && !w_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            ch    <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= w_bad_load;
            if (w_capture) begin
                dout  <= w_chan[w_eff];
                ch    <= w_eff;
                valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
        end else if (!scan) begin
            r_scan_cnt <= '0;
        end else if (le) begin
            r_scan_cnt <= (r_scan_cnt == c_LAST) ? '0 : r_scan_cnt + 1'b1;
        end
    end

`ifdef MUX_CAPTURE_ERRCNT_EN
    // Counts in step with err: bumps on the same edge that raises err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (w_bad_load && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_capture.sv
`default_nettype none
// Directed self-checking bench for mux_capture (N=3, W=2).
module tb_mux_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] idata = 6'b111001;
    logic [1:0] sel = 2'd0;
    logic       le = 1'b0;
    logic       scan = 1'b0;
    logic [1:0] dout;
    logic [1:0] ch;
    logic       valid;
    logic       err;
`ifdef MUX_CAPTURE_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    mux_capture #(.N(3), .W(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .idata (idata),
        .sel   (sel),
        .le    (le),
        .scan  (scan),
        .dout  (dout),
        .ch    (ch),
        .valid (valid),
        .err   (err)
`ifdef MUX_CAPTURE_ERRCNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_dout, input logic [1:0] e_ch,
                             input logic e_valid, input logic e_err);
        check({tag, ".dout"},  32'(dout),  32'(e_dout));
        check({tag, ".ch"},    32'(ch),    32'(e_ch));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".err"},   32'(err),   32'(e_err));
    endtask

    initial begin
        // Reset
        #1;
        check_out("reset_async", 2'b00, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check_out("reset_release", 2'b00, 2'd0, 1'b0, 1'b0);
`ifdef MUX_CAPTURE_ERRCNT_EN
        check("reset_errcnt", 32'(err_cnt), 32'd0);
`endif

        // Manual select
        le = 1'b1; sel = 2'd0;
        tick(); check_out("man_sel0", 2'b01, 2'd0, 1'b1, 1'b0);
        sel = 2'd1;
        tick(); check_out("man_sel1", 2'b10, 2'd1, 1'b1, 1'b0);
        sel = 2'd2;
        tick(); check_out("man_sel2", 2'b11, 2'd2, 1'b1, 1'b0);

        // Invalid select, two back-to-back
        sel = 2'd3;
        tick(); check_out("bad_1", 2'b11, 2'd2, 1'b1, 1'b1);
        tick(); check_out("bad_2", 2'b11, 2'd2, 1'b1, 1'b1);
`ifdef MUX_CAPTURE_ERRCNT_EN
        check("bad_errcnt", 32'(err_cnt), 32'd2);
`endif
        le = 1'b0;
        tick(); check_out("bad_clear", 2'b11, 2'd2, 1'b1, 1'b0);

        // Hold while le=0 despite data changes
        idata = 6'b111000;
        tick(); check_out("hold_a", 2'b11, 2'd2, 1'b1, 1'b0);
        idata = 6'b111010;
        tick(); check_out("hold_b", 2'b11, 2'd2, 1'b1, 1'b0);
        le = 1'b1; sel = 2'd0;
        tick(); check_out("hold_load", 2'b10, 2'd0, 1'b1, 1'b0);

        // Scan mode (sel=3 must be ignored, no err)
        idata = 6'b111001; scan = 1'b1; sel = 2'd3;
        tick(); check_out("scan_0", 2'b01, 2'd0, 1'b1, 1'b0);
        tick(); check_out("scan_1", 2'b10, 2'd1, 1'b1, 1'b0);
        tick(); check_out("scan_2", 2'b11, 2'd2, 1'b1, 1'b0);
        tick(); check_out("scan_3", 2'b01, 2'd0, 1'b1, 1'b0);
        tick(); check_out("scan_4", 2'b10, 2'd1, 1'b1, 1'b0);
        le = 1'b0;
        tick(); check_out("scan_pause_a", 2'b10, 2'd1, 1'b1, 1'b0);
        tick(); check_out("scan_pause_b", 2'b10, 2'd1, 1'b1, 1'b0);
        le = 1'b1;
        tick(); check_out("scan_resume", 2'b11, 2'd2, 1'b1, 1'b0);
        tick(); check_out("scan_wrap", 2'b01, 2'd0, 1'b1, 1'b0);

        // Async reset between edges, mid-scan
        #2 rst = 1'b1;
        #1;
        check_out("areset_mid", 2'b00, 2'd0, 1'b0, 1'b0);
`ifdef MUX_CAPTURE_ERRCNT_EN
        check("areset_errcnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b0;
        tick(); check_out("areset_first", 2'b01, 2'd0, 1'b1, 1'b0);
        tick(); check_out("areset_second", 2'b10, 2'd1, 1'b1, 1'b0);

        // Leaving scan clears the counter: first scan capture is channel 0 again
        scan = 1'b0; le = 1'b0;
        tick();
        scan = 1'b1; le = 1'b1;
        tick(); check_out("rescan_first", 2'b01, 2'd0, 1'b1, 1'b0);

        // Long run of invalid loads
        scan = 1'b0; sel = 2'd3;
        for (int i = 0; i < 300; i++) tick();
        check_out("sat_err", 2'b01, 2'd0, 1'b1, 1'b1);
`ifdef MUX_CAPTURE_ERRCNT_EN
        check("sat_errcnt", 32'(err_cnt), 32'd255);
        tick();
        check("sat_hold", 32'(err_cnt), 32'd255);
`endif
        le = 1'b0;
        tick(); check_out("sat_end", 2'b01, 2'd0, 1'b1, 1'b0);
`ifdef MUX_CAPTURE_ERRCNT_EN
        check("sat_final", 32'(err_cnt), 32'd255);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
